// File: rtl/wb_bus_sel_stage_if.sv
// ---------------------------------------------------------------------------
// wb_bus_sel_stage_if
//   Handshake/bus bundle for the registered writeback source selector.
//   Request side : in_valid, in_ready, sel, rd_addr, src_data, mem_valid
//   Result side  : out_valid, out_ready, out_data, out_rd, out_err
//   master modport: the environment (execute/memory datapath + register file)
//   slave modport : the selector stage itself
// ---------------------------------------------------------------------------
interface wb_bus_sel_stage_if #(
  parameter int XLEN = 32,
  parameter int NSRC = 4,
  parameter int SELW = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [SELW-1:0]      sel;
  logic [4:0]           rd_addr;
  logic [NSRC*XLEN-1:0] src_data;
  logic                 mem_valid;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_data;
  logic [4:0]           out_rd;
  logic                 out_err;

  modport master (
    output in_valid, sel, rd_addr, src_data, mem_valid, out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_err
  );

  modport slave (
    input  in_valid, sel, rd_addr, src_data, mem_valid, out_ready,
    output in_ready, out_valid, out_data, out_rd, out_err
  );
endinterface

// File: rtl/wb_bus_sel_stage.sv
// ---------------------------------------------------------------------------
// wb_bus_sel_stage
//   Registered writeback source selector. Picks one of NSRC source buses for
//   the register-file write port, holds it in an output register and uses a
//   valid/ready handshake on both sides. A request for the memory-load source
//   waits (WAIT_MEM) until mem_valid delivers the late load data.
//
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : wb_bus_sel_stage_if.slave
//          in_valid/in_ready/sel/rd_addr/src_data/mem_valid (request side)
//          out_valid/out_ready/out_data/out_rd/out_err      (result side)
//
// Configuration
//   WB_LINK_ADD_EN : when defined, source LINK_SRC is registered as src+4
//                    (wrapping), giving the JAL/JALR link value. When
//                    undefined, every source is passed unmodified.
// ---------------------------------------------------------------------------
module wb_bus_sel_stage #(
  parameter int XLEN     = 32,
  parameter int NSRC     = 4,
  parameter int SELW     = 2,
  parameter int MEM_SRC  = 1,
  parameter int LINK_SRC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_bus_sel_stage_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, FULL} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] out_data_reg, out_data_next;
  logic [4:0]      out_rd_reg, out_rd_next;
  logic            out_err_reg, out_err_next;
  logic [4:0]      pend_rd_reg, pend_rd_next;

  logic [XLEN-1:0] src_arr [NSRC];
  logic [XLEN-1:0] sel_data;
  logic [XLEN-1:0] acc_data;
  logic [XLEN-1:0] mem_data;
  logic            sel_oob;
  logic            is_mem_sel;
  logic            accept;

  // Unpack the flat source bus into one word per source.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_unpack
      assign src_arr[gi] = bus.src_data[gi*XLEN +: XLEN];
    end
  endgenerate

  assign sel_oob    = int'(bus.sel) >= NSRC;
  assign is_mem_sel = int'(bus.sel) == MEM_SRC;

  assign bus.in_ready  = (state_reg == IDLE) || ((state_reg == FULL) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_reg == FULL);
  assign bus.out_data  = out_data_reg;
  assign bus.out_rd    = out_rd_reg;
  assign bus.out_err   = out_err_reg;

  // Source mux; out-of-range selects leave sel_data at zero.
  always_comb begin
    sel_data = '0;
    for (int s = 0; s < NSRC; s++) begin
      if (int'(bus.sel) == s) begin
        sel_data = src_arr[s];
      end
    end
`ifdef WB_LINK_ADD_EN
    if (int'(bus.sel) == LINK_SRC) begin
      sel_data = sel_data + XLEN'(4);
    end
`endif
  end

  // x0 is hardwired: any result headed for register 0 is written as zero.
  assign acc_data = (sel_oob || (bus.rd_addr == 5'd0)) ? '0 : sel_data;
  assign mem_data = (pend_rd_reg == 5'd0) ? '0 : src_arr[MEM_SRC];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      out_data_reg <= '0;
      out_rd_reg   <= '0;
      out_err_reg  <= 1'b0;
      pend_rd_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      out_data_reg <= out_data_next;
      out_rd_reg   <= out_rd_next;
      out_err_reg  <= out_err_next;
      pend_rd_reg  <= pend_rd_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    out_data_next = out_data_reg;
    out_rd_next   = out_rd_reg;
    out_err_next  = out_err_reg;
    pend_rd_next  = pend_rd_reg;
    case (state_reg)
      IDLE, FULL: begin
        if (accept) begin
          // A load whose data is not here yet parks in WAIT_MEM; an
          // out-of-range select never matches MEM_SRC so it cannot stall.
          if (is_mem_sel && !bus.mem_valid) begin
            state_next   = WAIT_MEM;
            pend_rd_next = bus.rd_addr;
          end else begin
            state_next    = FULL;
            out_data_next = acc_data;
            out_rd_next   = bus.rd_addr;
            out_err_next  = sel_oob;
          end
        end else if ((state_reg == FULL) && bus.out_ready) begin
          state_next = IDLE;
        end
      end
      WAIT_MEM: begin
        if (bus.mem_valid) begin
          state_next    = FULL;
          out_data_next = mem_data;
          out_rd_next   = pend_rd_reg;
          out_err_next  = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_bus_sel_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_bus_sel_stage
//   Directed plus randomized stimulus for wb_bus_sel_stage (NSRC=3 so that
//   sel=3 is out of range). A transaction-level reference model predicts
//   in_ready and the held result.
// ---------------------------------------------------------------------------
module tb_wb_bus_sel_stage;
  localparam int XLEN     = 32;
  localparam int NSRC     = 3;
  localparam int SELW     = 2;
  localparam int MEM_SRC  = 1;
  localparam int LINK_SRC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_bus_sel_stage_if #(.XLEN(XLEN), .NSRC(NSRC), .SELW(SELW)) bus ();

  wb_bus_sel_stage #(
    .XLEN(XLEN), .NSRC(NSRC), .SELW(SELW), .MEM_SRC(MEM_SRC), .LINK_SRC(LINK_SRC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: is a result held, is a load outstanding, what is held.
  bit          m_have = 0;
  bit          m_wait = 0;
  logic [4:0]  m_pend = '0;
  logic [31:0] m_data = '0;
  logic [4:0]  m_rd   = '0;
  logic        m_err  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_val(input int s, input logic [4:0] rd,
                                          input logic [31:0] a0, a1, a2);
    logic [31:0] v;
    if (s >= NSRC) return 32'h0;
    v = (s == 0) ? a0 : (s == 1) ? a1 : a2;
`ifdef WB_LINK_ADD_EN
    if (s == LINK_SRC) v = v + 32'd4;
`endif
    if (rd == 5'd0) v = 32'h0;
    return v;
  endfunction

  // One clock cycle: drive at negedge, check in_ready, advance model, check result.
  task automatic step(input logic iv, input logic [1:0] isel, input logic [4:0] ird,
                      input logic [31:0] s0, s1, s2, input logic imem, input logic ordy);
    bit exp_ready;
    bit acc;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.sel       = isel;
    bus.rd_addr   = ird;
    bus.src_data  = {s2, s1, s0};
    bus.mem_valid = imem;
    bus.out_ready = ordy;
    #1;
    exp_ready = !m_wait && (!m_have || ordy);
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_ready});
    acc = iv && exp_ready;
    @(posedge clk);
    if (m_wait) begin
      if (imem) begin
        m_wait = 0;
        m_have = 1;
        m_data = ref_val(MEM_SRC, m_pend, s0, s1, s2);
        m_rd   = m_pend;
        m_err  = 1'b0;
      end
    end else begin
      if (m_have && ordy) m_have = 0;
      if (acc) begin
        if (int'(isel) == MEM_SRC && !imem) begin
          m_wait = 1;
          m_pend = ird;
        end else begin
          m_have = 1;
          m_data = ref_val(int'(isel), ird, s0, s1, s2);
          m_rd   = ird;
          m_err  = (int'(isel) >= NSRC);
        end
      end
    end
    #1;
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_have});
    if (m_have) begin
      chk("out_data", bus.out_data, m_data);
      chk("out_rd", {27'b0, bus.out_rd}, {27'b0, m_rd});
      chk("out_err", {31'b0, bus.out_err}, {31'b0, m_err});
    end
    $display("step iv=%0b sel=%0d rd=%0d mem=%0b ordy=%0b -> ov=%0b data=%h rd=%0d err=%0b",
             iv, isel, ird, imem, ordy, bus.out_valid, bus.out_data, bus.out_rd, bus.out_err);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_err", {31'b0, bus.out_err}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    m_have = 0;
    m_wait = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("reset pulse done");
  endtask

  initial begin
    logic [1:0]  rs;
    logic [4:0]  rr;
    logic [31:0] r0, r1, r2;
    bus.in_valid  = 1'b0;
    bus.sel       = '0;
    bus.rd_addr   = '0;
    bus.src_data  = '0;
    bus.mem_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Streaming from source 0 with a ready sink.
    step(1, 2'd0, 5'd5, 32'h0000_1234, 32'h1, 32'h2, 0, 1);
    chk("t2_data", bus.out_data, 32'h0000_1234);
    step(1, 2'd0, 5'd6, 32'h0000_5678, 32'h1, 32'h2, 0, 1);
    step(1, 2'd2, 5'd7, 32'h0, 32'h1, 32'h0000_0100, 0, 1);

    // Reset in the middle of the stream.
    pulse_reset();

    // Late load: mem_valid low for 3 cycles.
    step(1, 2'd1, 5'd9, 32'h0, 32'h0, 32'h0, 0, 1);
    step(0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 1);
    step(0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 1);
    step(0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 1);
    step(0, 2'd0, 5'd0, 32'h0, 32'hDEAD_BEEF, 32'h0, 1, 1);
    chk("t3_data", bus.out_data, 32'hDEAD_BEEF);

    // Back-pressure: held for 4 cycles, then accepted when out_ready rises.
    step(1, 2'd0, 5'd3, 32'hAAAA_0001, 32'h0, 32'h0, 0, 0);
    repeat (4) step(1, 2'd0, 5'd4, 32'hBBBB_0002, 32'h0, 32'h0, 0, 0);
    step(1, 2'd0, 5'd4, 32'hBBBB_0002, 32'h0, 32'h0, 0, 1);
    step(0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 1);

    // Out-of-range select and the x0 destination.
    step(1, 2'd3, 5'd8, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 0, 1);
    chk("t5_err", {31'b0, bus.out_err}, 32'd1);
    step(1, 2'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 1);
    chk("t5_x0", bus.out_data, 32'h0);

    // Link source with wrap.
    step(1, 2'd2, 5'd1, 32'h0, 32'h0, 32'hFFFF_FFFC, 0, 1);
`ifdef WB_LINK_ADD_EN
    chk("t6_link", bus.out_data, 32'h0000_0000);
`else
    chk("t6_link", bus.out_data, 32'hFFFF_FFFC);
`endif

    // Reset while a load is pending; the later mem_valid is ignored.
    step(1, 2'd1, 5'd10, 32'h0, 32'h0, 32'h0, 0, 1);
    pulse_reset();
    step(0, 2'd0, 5'd0, 32'h0, 32'h5555_5555, 32'h0, 1, 1);
    chk("t6_ignored_mem", {31'b0, bus.out_valid}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      rs = 2'($urandom_range(0, 3));
      rr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      r0 = $urandom;
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
      step(1'($urandom_range(0, 1)), rs, rr, r0, r1, r2,
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
